// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit for the picoMIPS core.
// Fetches and latches the opcode, steers the ALU through execute,
// stretches multiply to MUL_CYCLES, runs the sw8 input handshake,
// evaluates branches from latched flags and drives PC/regfile strobes.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   opcode     in   opcode field at current PC
//   alu_flags  in   live ALU flags {V,N,Z,C}
//   sw8        in   synchronised handshake switch
//   ir_load    out  instruction register load strobe
//   func       out  ALU function code
//   a_sel      out  ALU A input select
//   b_sel      out  ALU B input select
//   imm        out  ALU B takes the immediate
//   reg_we     out  register-file write enable
//   pc_incr    out  PC <= PC+1
//   pc_load    out  PC <= branch target
//   flags_q    out  latched {V,N,Z,C}
//   halted     out  core halted
//   illegal    out  sticky undefined-opcode indicator
module alu_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int OPW        = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [3:0]     alu_flags,
    input  logic           sw8,
    output logic           ir_load,
    output logic [2:0]     func,
    output logic [1:0]     a_sel,
    output logic [1:0]     b_sel,
    output logic           imm,
    output logic           reg_we,
    output logic           pc_incr,
    output logic           pc_load,
    output logic [3:0]     flags_q,
    output logic           halted,
    output logic           illegal
);

    // ALU function and input-select encodings (alucodes)
    localparam logic [2:0] RA     = 3'd0;
    localparam logic [2:0] RB     = 3'd1;
    localparam logic [2:0] RADD   = 3'd2;
    localparam logic [2:0] RSUB   = 3'd3;
    localparam logic [2:0] RMULL  = 3'd4;
    localparam logic [1:0] REG    = 2'd0;
    localparam logic [1:0] SW_7_0 = 2'd1;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(4);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5);
    localparam logic [OPW-1:0] OP_MULI = OPW'(6);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(7);
    localparam logic [OPW-1:0] OP_IN   = OPW'(8);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(9);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(10);
    localparam logic [OPW-1:0] OP_HALT = OPW'(11);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MULW,
        S_INHI,
        S_INLO,
        S_HALT
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     flags_d;
    logic           illegal_q, illegal_d;

    logic           ir_load_c, reg_we_c, pc_incr_c, pc_load_c;
    logic [2:0]     func_c;
    logic [1:0]     a_sel_c, b_sel_c;
    logic           imm_c;
    logic           active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // ALU steering, decoded only from the latched opcode
    assign active = (state_q == S_EXEC) || (state_q == S_MULW) ||
                    (state_q == S_INHI) || (state_q == S_INLO);

    always_comb begin
        func_c  = RA;
        a_sel_c = REG;
        b_sel_c = REG;
        imm_c   = 1'b0;
        if (active) begin
            case (op_q)
                OP_ADD:  func_c = RADD;
                OP_ADDI: begin
                    func_c = RADD;
                    imm_c  = 1'b1;
                end
                OP_SUB:  func_c = RSUB;
                OP_SUBI: begin
                    func_c = RSUB;
                    imm_c  = 1'b1;
                end
                OP_MUL:  func_c = RMULL;
                OP_MULI: begin
                    func_c = RMULL;
                    imm_c  = 1'b1;
                end
                OP_MOV:  func_c = RB;
                OP_IN:   a_sel_c = SW_7_0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        ir_load_c = 1'b0;
        reg_we_c  = 1'b0;
        pc_incr_c = 1'b0;
        pc_load_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_load_c = 1'b1;
                op_d      = opcode;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_NOP: pc_incr_c = 1'b1;
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        reg_we_c  = 1'b1;
                        pc_incr_c = 1'b1;
                        flags_d   = alu_flags;
                    end
                    OP_MOV: begin
                        reg_we_c  = 1'b1;
                        pc_incr_c = 1'b1;
                    end
                    OP_MUL, OP_MULI: begin
                        if (MUL_CYCLES == 1) begin
                            reg_we_c  = 1'b1;
                            pc_incr_c = 1'b1;
                        end else begin
                            cnt_d   = MUL_LOAD;
                            state_d = S_MULW;
                        end
                    end
                    OP_IN:   state_d = S_INHI;
                    OP_BEQ: begin
                        pc_load_c = flags_q[1];
                        pc_incr_c = ~flags_q[1];
                    end
                    OP_BNE: begin
                        pc_load_c = ~flags_q[1];
                        pc_incr_c = flags_q[1];
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        pc_incr_c = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MULW: begin
                // EXEC already spent one cycle, so the decremented
                // count reaching zero marks the last execute cycle.
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    reg_we_c  = 1'b1;
                    pc_incr_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_INHI: begin
                if (sw8) state_d = S_INLO;
            end
            S_INLO: begin
                if (!sw8) begin
                    reg_we_c  = 1'b1;
                    pc_incr_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while reset is held, independent of state
    assign ir_load = ir_load_c & ~reset;
    assign reg_we  = reg_we_c & ~reset;
    assign pc_incr = pc_incr_c & ~reset;
    assign pc_load = pc_load_c & ~reset;
    assign func    = reset ? RA : func_c;
    assign a_sel   = reset ? REG : a_sel_c;
    assign b_sel   = reset ? REG : b_sel_c;
    assign imm     = imm_c & ~reset;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed, table-driven check of alu_sequencer
// (MUL_CYCLES=3) plus hand-written multi-cycle sequences.
module tb_alu_sequencer;

    localparam logic [2:0] RA    = 3'd0;
    localparam logic [2:0] RB    = 3'd1;
    localparam logic [2:0] RADD  = 3'd2;
    localparam logic [2:0] RSUB  = 3'd3;
    localparam logic [2:0] RMULL = 3'd4;
    localparam logic [1:0] REG   = 2'd0;
    localparam logic [1:0] SW    = 2'd1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic [3:0] alu_flags = 4'h0;
    logic       sw8 = 1'b0;
    logic       ir_load, imm, reg_we, pc_incr, pc_load, halted, illegal;
    logic [2:0] func;
    logic [1:0] a_sel, b_sel;
    logic [3:0] flags_q;

    int nvec = 0;
    int nerr = 0;

    alu_sequencer #(.MUL_CYCLES(3), .OPW(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .alu_flags(alu_flags), .sw8(sw8), .ir_load(ir_load),
        .func(func), .a_sel(a_sel), .b_sel(b_sel), .imm(imm),
        .reg_we(reg_we), .pc_incr(pc_incr), .pc_load(pc_load),
        .flags_q(flags_q), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fl;
        logic [2:0] f;
        logic [1:0] a;
        logic [1:0] b;
        logic       im;
        logic       we;
        logic       inc;
        logic       ld;
        int         cyc;
        logic [3:0] ef;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Starts before the FETCH negedge, ends 1 after the edge that
    // leaves the last execute cycle (next FETCH in progress).
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        opcode = v.op;
        alu_flags = v.fl;
        #1;
        chk("fetch.ir_load", 32'(ir_load), 32'd1);
        for (int c = 0; c < v.cyc; c++) begin
            @(negedge clk);
            opcode = 4'hB;
            #1;
            chk("exec.ir_load", 32'(ir_load), 32'd0);
            chk("exec.func", 32'(func), 32'(v.f));
            chk("exec.a_sel", 32'(a_sel), 32'(v.a));
            chk("exec.b_sel", 32'(b_sel), 32'(v.b));
            chk("exec.imm", 32'(imm), 32'(v.im));
            chk("exec.reg_we", 32'(reg_we),
                (c == v.cyc - 1) ? 32'(v.we) : 32'd0);
            chk("exec.pc_incr", 32'(pc_incr),
                (c == v.cyc - 1) ? 32'(v.inc) : 32'd0);
            chk("exec.pc_load", 32'(pc_load),
                (c == v.cyc - 1) ? 32'(v.ld) : 32'd0);
        end
        @(posedge clk);
        #1;
        chk("flags_q", 32'(flags_q), 32'(v.ef));
    endtask

    // pat[c] is sw8 during execute cycle c; strobes expected in cycle n-1
    task automatic run_in(input logic [15:0] pat, input int n);
        @(negedge clk);
        opcode = 4'h8;
        sw8 = 1'b0;
        #1;
        chk("in.fetch", 32'(ir_load), 32'd1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            opcode = 4'hB;
            sw8 = pat[c];
            #1;
            chk("in.a_sel", 32'(a_sel), 32'(SW));
            chk("in.func", 32'(func), 32'(RA));
            chk("in.reg_we", 32'(reg_we), (c == n - 1) ? 32'd1 : 32'd0);
            chk("in.pc_incr", 32'(pc_incr), (c == n - 1) ? 32'd1 : 32'd0);
            chk("in.ir_load", 32'(ir_load), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("in.refetch", 32'(ir_load), 32'd1);
    endtask

    vec_t tbl[12];
    vec_t vill;
    vec_t vadd;

    initial begin
        tbl[0]  = '{4'h1, 4'b0101, RADD,  REG, REG, 0, 1, 1, 0, 1, 4'b0101};
        tbl[1]  = '{4'h5, 4'b1111, RMULL, REG, REG, 0, 1, 1, 0, 3, 4'b0101};
        tbl[2]  = '{4'h2, 4'b0000, RADD,  REG, REG, 1, 1, 1, 0, 1, 4'b0000};
        tbl[3]  = '{4'h6, 4'b1010, RMULL, REG, REG, 1, 1, 1, 0, 3, 4'b0000};
        tbl[4]  = '{4'h3, 4'b0010, RSUB,  REG, REG, 0, 1, 1, 0, 1, 4'b0010};
        tbl[5]  = '{4'h9, 4'b0000, RA,    REG, REG, 0, 0, 0, 1, 1, 4'b0010};
        tbl[6]  = '{4'hA, 4'b0000, RA,    REG, REG, 0, 0, 1, 0, 1, 4'b0010};
        tbl[7]  = '{4'h4, 4'b0000, RSUB,  REG, REG, 1, 1, 1, 0, 1, 4'b0000};
        tbl[8]  = '{4'h9, 4'b0010, RA,    REG, REG, 0, 0, 1, 0, 1, 4'b0000};
        tbl[9]  = '{4'hA, 4'b0010, RA,    REG, REG, 0, 0, 0, 1, 1, 4'b0000};
        tbl[10] = '{4'h7, 4'b1111, RB,    REG, REG, 0, 1, 1, 0, 1, 4'b0000};
        tbl[11] = '{4'h0, 4'b1111, RA,    REG, REG, 0, 0, 1, 0, 1, 4'b0000};
        vill    = '{4'hE, 4'b1111, RA,    REG, REG, 0, 0, 1, 0, 1, 4'b0000};
        vadd    = '{4'h1, 4'b1001, RADD,  REG, REG, 0, 1, 1, 0, 1, 4'b1001};

        #1;
        chk("rst.ir_load", 32'(ir_load), 32'd0);
        chk("rst.strobes", 32'({reg_we, pc_incr, pc_load}), 32'd0);
        chk("rst.func", 32'(func), 32'(RA));
        chk("rst.sel", 32'({a_sel, b_sel, imm}), 32'd0);
        chk("rst.flags", 32'(flags_q), 32'd0);
        chk("rst.status", 32'({halted, illegal}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        run_in(16'h00E0, 9);
        run_in(16'h0003, 3);

        chk("illegal.before", 32'(illegal), 32'd0);
        run_vec(vill);
        chk("illegal.set", 32'(illegal), 32'd1);
        run_vec(vadd);
        chk("illegal.sticky", 32'(illegal), 32'd1);

        // reset in the last multiply cycle, while reg_we is high
        @(negedge clk);
        opcode = 4'h5;
        repeat (3) @(negedge clk);
        #1;
        chk("mulw.last_we", 32'(reg_we), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst.strobes",
            32'({ir_load, reg_we, pc_incr, pc_load}), 32'd0);
        chk("mrst.func", 32'(func), 32'(RA));
        chk("mrst.flags", 32'(flags_q), 32'd0);
        chk("mrst.illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mrst.ir_load", 32'(ir_load), 32'd1);
        run_vec(tbl[0]);

        // HALT
        @(negedge clk);
        opcode = 4'hB;
        #1;
        chk("halt.fetch", 32'(ir_load), 32'd1);
        @(negedge clk);
        opcode = 4'h1;
        #1;
        chk("halt.exec", 32'({ir_load, reg_we, pc_incr, pc_load}), 32'd0);
        chk("halt.exec_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            opcode = 4'(i);
            #1;
            chk("halt.halted", 32'(halted), 32'd1);
            chk("halt.quiet",
                32'({ir_load, reg_we, pc_incr, pc_load}), 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("halt.reset", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("halt.restart", 32'(ir_load), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit for the picoMIPS core.
- Latches the 4-bit opcode, steers the ALU (func, a_sel, b_sel, imm) through fetch/execute, and stretches multiply to a fixed cycle count.
- Runs a two-phase switch handshake for input instructions, evaluates conditional branches from latched ALU flags, and drives register-file write enable and PC update.
- Sits between program memory/PC and the ALU/register file; ALU function and input-select encodings come from alucodes.sv.

Parameters:
- MUL_CYCLES, 2, execute cycles for multiply (1..15); lets the multiplier path be multicycle.
- OPW, 4, opcode field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPW  opcode field from program memory at current PC.
- alu_flags  in  4  ALU flags {V,N,Z,C}.
- sw8  in  1  switches[8], handshake input, already synchronised.
- ir_load  out  1  latch instruction register.
- func  out  3  ALU function code.
- a_sel  out  2  ALU A input select.
- b_sel  out  2  ALU B input select.
- imm  out  1  ALU B takes the immediate.
- reg_we  out  1  register-file write enable.
- pc_incr  out  1  PC <= PC+1.
- pc_load  out  1  PC <= branch target; never asserted together with pc_incr.
- flags_q  out  4  latched {V,N,Z,C}.
- halted  out  1  core halted.
- illegal  out  1  sticky, an undefined opcode was executed.

Behaviour:
- States: FETCH, EXEC, MULW, INHI, INLO, HALT.
- Reset (async, any state, including mid-multiply or mid-handshake):
  - State goes to FETCH; flags_q=0; illegal=0; halted=0; multiply counter=0.
  - All strobes (ir_load, reg_we, pc_incr, pc_load) are 0.
  - func=`RA, a_sel=`REG, b_sel=`REG, imm=0.
- FETCH:
  - ir_load=1 for exactly one cycle; the opcode is captured into an internal opcode register.
  - Next state is EXEC. All ALU controls are decoded from the registered opcode, never the live input.
- Opcodes:
  - 0 NOP: no write; pc_incr.
  - 1 ADD: `RADD, REG/REG.
  - 2 ADDI: `RADD, imm=1.
  - 3 SUB: `RSUB, REG/REG.
  - 4 SUBI: `RSUB, imm=1.
  - 5 MUL: `RMULL, REG/REG.
  - 6 MULI: `RMULL, imm=1.
  - 7 MOV: `RB.
  - 8 IN: `RA, a_sel=`SW_7_0.
  - 9 BEQ: branch if flags_q[1]=1.
  - A BNE: branch if flags_q[1]=0.
  - B HALT.
  - C–F: illegal; execute as NOP and set illegal.
- EXEC, single-cycle ops (ADD, ADDI, SUB, SUBI, MOV, NOP):
  - One cycle; reg_we=1 (except NOP) and pc_incr=1 in that cycle; next state FETCH.
  - ADD/ADDI/SUB/SUBI also load flags_q <= alu_flags on that edge. No other op touches flags_q.
- MUL/MULI:
  - EXEC loads the counter with MUL_CYCLES-1 and goes to MULW; if MUL_CYCLES=1, MUL completes in EXEC.
  - MULW holds the ALU controls and decrements the counter each cycle.
  - reg_we and pc_incr are asserted only in the cycle the counter reads 0; then FETCH.
  - Total execute cycles = MUL_CYCLES exactly.
- IN:
  - EXEC goes to INHI, which waits for sw8=1, then INLO.
  - INLO waits for sw8=0. On the cycle sw8 is seen 0: reg_we=1, pc_incr=1, with a_sel=`SW_7_0 held throughout; next FETCH.
  - If sw8 is already 1 at EXEC, INHI passes through in one cycle.
  - Wait is unbounded; no timeout.
- BEQ/BNE:
  - One EXEC cycle; pc_load=1 if the condition holds, else pc_incr=1; reg_we=0.
  - The condition uses flags_q, not live alu_flags.
- HALT:
  - EXEC goes to HALT; halted=1 from the next cycle.
  - No strobes are asserted. Only reset exits HALT.
- Every instruction asserts exactly one of pc_incr/pc_load exactly once, except HALT (neither).

Test Plan:
- Reset asserted mid-MULW (MUL_CYCLES=3) -> all strobes 0 immediately (asynchronously); after release, ir_load=1 on the first edge; illegal=0, flags_q=0.
- Program ADD(opcode 1) then MUL(5), MUL_CYCLES=3 -> ADD: ir_load cycle, then one cycle with func=`RADD, reg_we=1, pc_incr=1. MUL: ir_load, then 3 cycles with func=`RMULL, reg_we/pc_incr only on the third.
- SUB with alu_flags=4'b0010, then BEQ(9) -> flags_q=4'b0010, pc_load=1, pc_incr=0. Repeat with alu_flags=0 -> pc_incr=1, pc_load=0. BNE(A) gives the inverse.
- IN(8): sw8 low 5 cycles, high 3 cycles, low -> a_sel=`SW_7_0 throughout; reg_we=1 and pc_incr=1 only in the first cycle after sw8 returns low. Also: sw8 already high at EXEC -> INHI lasts one cycle.
- Opcode E -> treated as NOP (reg_we=0, pc_incr=1); illegal=1 and stays 1 through later valid instructions until reset.
- HALT(B) -> halted=1; further opcode changes produce no ir_load/strobes for 20 cycles; reset clears halted.
